// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame controller.
// No logic of its own; pure definitions.
// No flow control here.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    RELEASE = 3'd4
  } state_e;

  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Running checksum is a plain modulo-256 byte sum.
  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/uart_frame_ctrl_if.sv
// Byte-in / payload-stream-out bundle of the UART frame controller.
// Wires only, no latency.
// out_valid/out_ready carry the stream handshake; rx side has none.
interface uart_frame_ctrl_if #(
  parameter int MAX_LEN = 16
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          frame_done;
  logic [LW-1:0] frame_len;
  logic          frame_err;
  logic [1:0]    err_code;
  logic          overrun;
  logic          busy;

  // Controller side.
  modport slave (
    input  rx_data, rx_valid, out_ready,
    output out_data, out_valid, out_last, frame_done, frame_len,
           frame_err, err_code, overrun, busy
  );

  // Byte source / payload sink side.
  modport master (
    output rx_data, rx_valid, out_ready,
    input  out_data, out_valid, out_last, frame_done, frame_len,
           frame_err, err_code, overrun, busy
  );
endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN x 8 register array, one write port, one async read port.
// Write lands on the clock edge; read is combinational from raddr.
// No flow control; the controller owns sequencing. Contents are not reset.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  // Capture one payload byte per write strobe.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frames received bytes (SYNC, LEN, payload, CSUM), validates them and streams the payload out.
// First payload byte is offered the cycle after the CSUM byte is sampled; status pulses are registered.
// Payload holds on out_ready low; bytes arriving while releasing are dropped and flagged as overrun.
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC    = SYNC_DEFAULT,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             reset,
  uart_frame_ctrl_if.slave bus
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT - 1);
  localparam logic [8:0]    LEN_MAX = 9'(MAX_LEN);

  state_e        state_q;
  logic [7:0]    len_q;
  logic [7:0]    sum_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [TW-1:0] idle_cnt_q;
  logic [TW-1:0] idle_cnt_d;
  logic [LW-1:0] frame_len_q;
  logic [1:0]    err_code_q;
  logic          frame_done_q;
  logic          frame_err_q;
  logic          overrun_q;
  logic          busy_q;

  logic          buf_we;
  logic [7:0]    buf_rdata;
  logic          wr_last;
  logic          rd_last;
  logic          out_valid;
  logic          tmo_hit;
  logic          csum_ok;

  assign buf_we  = (state_q == PAYLOAD) && bus.rx_valid;
  assign wr_last = (8'(wr_ptr_q) == len_q - 8'd1);
  assign rd_last = (8'(rd_ptr_q) == len_q - 8'd1);
  assign csum_ok = (csum_add(sum_q, bus.rx_data) == 8'h00);

  // An arriving byte always beats the timeout in the same cycle.
  assign tmo_hit = !bus.rx_valid && (idle_cnt_q == TMO_LIM) &&
                   (state_q == LEN || state_q == PAYLOAD || state_q == CSUM);

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr_q),
    .wdata (bus.rx_data),
    .raddr (rd_ptr_q),
    .rdata (buf_rdata)
  );

  // Inter-byte gap counter: only runs while waiting for frame bytes, saturates.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (bus.rx_valid || state_q == IDLE || state_q == RELEASE) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != {TW{1'b1}}) begin
      idle_cnt_d = idle_cnt_q + TW'(1);
    end
  end

  // Frame sequencer with registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      sum_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      idle_cnt_q   <= '0;
      frame_len_q  <= '0;
      err_code_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      idle_cnt_q   <= idle_cnt_d;

      unique case (state_q)
        IDLE: begin
          if (bus.rx_valid && bus.rx_data == SYNC) begin
            state_q <= LEN;
            busy_q  <= 1'b1;
          end
        end

        LEN: begin
          if (bus.rx_valid) begin
            len_q <= bus.rx_data;
            sum_q <= bus.rx_data;
            if ({1'b0, bus.rx_data} > LEN_MAX) begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_LEN;
            end else if (bus.rx_data == 8'h00) begin
              state_q <= CSUM;
            end else begin
              state_q  <= PAYLOAD;
              wr_ptr_q <= '0;
            end
          end else if (tmo_hit) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_TMO;
          end
        end

        PAYLOAD: begin
          if (bus.rx_valid) begin
            sum_q    <= csum_add(sum_q, bus.rx_data);
            wr_ptr_q <= wr_ptr_q + AW'(1);
            if (wr_last) state_q <= CSUM;
          end else if (tmo_hit) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_TMO;
          end
        end

        CSUM: begin
          if (bus.rx_valid) begin
            if (csum_ok) begin
              frame_done_q <= 1'b1;
              frame_len_q  <= LW'(len_q);
              rd_ptr_q     <= '0;
              if (len_q != 8'h00) begin
                state_q <= RELEASE;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_CSUM;
            end
          end else if (tmo_hit) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_TMO;
          end
        end

        RELEASE: begin
          // Capture is suspended while the buffer drains; anything arriving is lost.
          if (bus.rx_valid) overrun_q <= 1'b1;
          if (bus.out_ready) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            if (rd_last) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stream outputs decode registered state only, so out_ready never feeds back combinationally.
  assign out_valid      = (state_q == RELEASE);
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_valid ? buf_rdata : 8'h00;
  assign bus.out_last   = out_valid && rd_last;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_len  = frame_len_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.err_code   = err_code_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = busy_q;

endmodule
